// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage: single-cycle ALU with result forwarding plus iterative shift-add multiplier
// Optional signed high multiplies (MULH/MULHSU) are built when EX_MUL_SIGNED_EN is defined.
module ex_stage_mc #(
    parameter int XLEN       = 32,
    parameter int REG_IDX_W  = 3,
    parameter int WB_CTRL_W  = 2,
    parameter int MEM_CTRL_W = 3,
    parameter int IMM_W      = 32,
    parameter int ERR_W      = 3,
    parameter logic [ERR_W-1:0] ERR_ILLEGAL_ALU = 3'd4,
    parameter int MUL_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  nop,
    output logic                  done,
    output logic [XLEN-1:0]       res,
    output logic [XLEN-1:0]       current_pc_addr,
    output logic [REG_IDX_W-1:0]  dest,
    output logic [REG_IDX_W-1:0]  reg_extra,
    output logic [WB_CTRL_W-1:0]  wb_ctrl,
    output logic [MEM_CTRL_W-1:0] mem_ctrl,
    output logic [IMM_W-1:0]      data_imm,
    output logic                  nop_statue,
    output logic [ERR_W-1:0]      error_code,
    output logic [REG_IDX_W-1:0]  rs1,
    output logic [REG_IDX_W-1:0]  rs2,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       id_data_x,
    input  logic [XLEN-1:0]       id_data_y,
    input  logic                  id_is_x_reg,
    input  logic                  id_is_y_reg,
    input  logic [XLEN-1:0]       id_current_pc_addr,
    input  logic [REG_IDX_W-1:0]  id_dest,
    input  logic [REG_IDX_W-1:0]  id_reg_extra,
    input  logic [4:0]            id_alu_ctrl,
    input  logic [WB_CTRL_W-1:0]  id_wb_ctrl,
    input  logic [MEM_CTRL_W-1:0] id_mem_ctrl,
    input  logic [IMM_W-1:0]      id_data_imm,
    input  logic                  id_nop_statue,
    input  logic [ERR_W-1:0]      id_error_code
);
    localparam int N     = XLEN / MUL_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [2*XLEN-1:0]     prod, prod_fin;
    logic [XLEN-1:0]       mcand, op_x, op_y, mag_x, mag_y, alu_res, mul_res;
    logic [2:0]            mop, alu_op;
    logic                  mul_mode, sub, bubble, mul_ok, start, illegal, fwd_x, fwd_y;
    logic [XLEN-1:0]       l_pc;
    logic [REG_IDX_W-1:0]  l_dest, l_extra;
    logic [WB_CTRL_W-1:0]  l_wb;
    logic [MEM_CTRL_W-1:0] l_mem;
    logic [IMM_W-1:0]      l_imm;

    // One radix-2^MUL_BITS step: add multiplicand*digit to the high half, shift right.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p, input logic [XLEN-1:0] m);
        logic [XLEN+MUL_BITS-1:0]   partial, upper;
        logic [2*XLEN+MUL_BITS-1:0] wide;
        partial = {{MUL_BITS{1'b0}}, m} * {{XLEN{1'b0}}, p[MUL_BITS-1:0]};
        upper   = {{MUL_BITS{1'b0}}, p[2*XLEN-1:XLEN]} + partial;
        wide    = {upper, p[XLEN-1:0]};
        return wide[2*XLEN+MUL_BITS-1:MUL_BITS];
    endfunction

    assign rs1      = id_data_x[REG_IDX_W-1:0];
    assign rs2      = id_data_y[REG_IDX_W-1:0];
    assign alu_op   = id_alu_ctrl[2:0];
    assign sub      = id_alu_ctrl[3];
    assign mul_mode = id_alu_ctrl[4];
    assign bubble   = nop | id_nop_statue;

    assign fwd_x = !nop_statue && (error_code == '0) && (dest != '0) && (rs1 == dest);
    assign fwd_y = !nop_statue && (error_code == '0) && (dest != '0) && (rs2 == dest);
    assign op_x  = !id_is_x_reg ? id_data_x : (fwd_x ? res : rs1_data);
    assign op_y  = !id_is_y_reg ? id_data_y : (fwd_y ? res : rs2_data);

    always_comb begin
        case (alu_op)
            3'b000, 3'b011: mul_ok = 1'b1;
`ifdef EX_MUL_SIGNED_EN
            3'b001, 3'b010: mul_ok = 1'b1;
`endif
            default:        mul_ok = 1'b0;
        endcase
    end

    assign start   = mul_mode && !bubble && (id_error_code == '0) && mul_ok;
    assign illegal = mul_mode && (id_error_code == '0) && !mul_ok;

`ifdef EX_MUL_SIGNED_EN
    logic x_neg, y_neg, neg_q;
    always_comb begin
        x_neg = ((alu_op == 3'b001) || (alu_op == 3'b010)) && op_x[XLEN-1];
        y_neg = (alu_op == 3'b001) && op_y[XLEN-1];
        mag_x = x_neg ? -op_x : op_x;
        mag_y = y_neg ? -op_y : op_y;
    end
`else
    assign mag_x = op_x;
    assign mag_y = op_y;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = op_x + (sub ? ~op_y : op_y) + {{(XLEN-1){1'b0}}, sub};
            3'b001: alu_res = op_x << op_y[SH_W-1:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_x) < $signed(op_y))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_x < op_y)};
            3'b100: alu_res = op_x ^ op_y;
            3'b101: begin
                if (sub) alu_res = $signed(op_x) >>> op_y[SH_W-1:0];
                else     alu_res = op_x >> op_y[SH_W-1:0];
            end
            3'b110: alu_res = op_x | op_y;
            default: alu_res = op_x & op_y;
        endcase
        if (mul_mode) alu_res = '0;
    end

    // The last shift-add step is folded into the completion cycle.
    always_comb begin
        prod_fin = mul_step(prod, mcand);
`ifdef EX_MUL_SIGNED_EN
        if (neg_q) prod_fin = -prod_fin;
`endif
        mul_res = (mop == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mop    <= '0;
            l_pc   <= '0;
            l_dest <= '0;
            l_extra <= '0;
            l_wb   <= '0;
            l_mem  <= '0;
            l_imm  <= '0;
`ifdef EX_MUL_SIGNED_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cnt     <= CNT_N;
                prod    <= {{XLEN{1'b0}}, mag_y};
                mcand   <= mag_x;
                mop     <= alu_op;
                l_pc    <= id_current_pc_addr;
                l_dest  <= id_dest;
                l_extra <= id_reg_extra;
                l_wb    <= id_wb_ctrl;
                l_mem   <= id_mem_ctrl;
                l_imm   <= id_data_imm;
`ifdef EX_MUL_SIGNED_EN
                neg_q   <= x_neg ^ y_neg;
`endif
            end else if (state == BUSY && cnt > CNT_ONE) begin
                prod <= mul_step(prod, mcand);
                cnt  <= cnt - CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            default: if (cnt == CNT_ONE && enable) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = (state == BUSY) ? (cnt == CNT_ONE) : !start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res             <= '0;
            current_pc_addr <= '0;
            dest            <= '0;
            reg_extra       <= '0;
            wb_ctrl         <= '0;
            mem_ctrl        <= '0;
            data_imm        <= '0;
            nop_statue      <= 1'b1;
            error_code      <= '0;
        end else if (enable && done) begin
            if (state == BUSY) begin
                res             <= mul_res;
                current_pc_addr <= l_pc;
                dest            <= l_dest;
                reg_extra       <= l_extra;
                wb_ctrl         <= l_wb;
                mem_ctrl        <= l_mem;
                data_imm        <= l_imm;
                nop_statue      <= 1'b0;
                error_code      <= '0;
            end else begin
                res             <= alu_res;
                current_pc_addr <= id_current_pc_addr;
                dest            <= id_dest;
                reg_extra       <= id_reg_extra;
                wb_ctrl         <= id_wb_ctrl;
                mem_ctrl        <= id_mem_ctrl;
                data_imm        <= id_data_imm;
                nop_statue      <= bubble;
                error_code      <= illegal ? ERR_ILLEGAL_ALU : id_error_code;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - randomized self-checking bench for ex_stage_mc against an arithmetic reference model
module tb_ex_stage_mc;
    logic        clk = 1'b0;
    logic        reset, enable, nop, done;
    logic [31:0] res, current_pc_addr, rs1_data, rs2_data, id_data_x, id_data_y, id_current_pc_addr, id_data_imm, data_imm;
    logic [2:0]  dest, reg_extra, rs1, rs2, id_dest, id_reg_extra, mem_ctrl, id_mem_ctrl, error_code, id_error_code;
    logic [1:0]  wb_ctrl, id_wb_ctrl;
    logic        nop_statue, id_is_x_reg, id_is_y_reg, id_nop_statue;
    logic [4:0]  id_alu_ctrl;

    logic [31:0] rf [8];
    logic [31:0] exp_res;
    logic [2:0]  exp_dest, exp_err;
    logic        exp_nop;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1];
    assign rs2_data = rf[rs2];

    ex_stage_mc dut (
        .clk(clk), .reset(reset), .enable(enable), .nop(nop), .done(done),
        .res(res), .current_pc_addr(current_pc_addr), .dest(dest), .reg_extra(reg_extra),
        .wb_ctrl(wb_ctrl), .mem_ctrl(mem_ctrl), .data_imm(data_imm), .nop_statue(nop_statue),
        .error_code(error_code), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .id_data_x(id_data_x), .id_data_y(id_data_y), .id_is_x_reg(id_is_x_reg), .id_is_y_reg(id_is_y_reg),
        .id_current_pc_addr(id_current_pc_addr), .id_dest(id_dest), .id_reg_extra(id_reg_extra),
        .id_alu_ctrl(id_alu_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_mem_ctrl(id_mem_ctrl),
        .id_data_imm(id_data_imm), .id_nop_statue(id_nop_statue), .id_error_code(id_error_code)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [31:0] v, input logic isr);
        logic [2:0] idx;
        idx = v[2:0];
        if (!isr) return v;
        if (!exp_nop && exp_err == 3'd0 && exp_dest != 3'd0 && idx == exp_dest) return exp_res;
        return rf[idx];
    endfunction

    task automatic model(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic bub,
                         input logic [2:0] ein, output logic [31:0] r, output logic [2:0] e, output int lat);
        logic [63:0] p;
        logic        legal;
        r = 32'd0; e = ein; lat = 0; p = 64'd0;
        if (!ctrl[4]) begin
            case (ctrl[2:0])
                3'd0: r = ctrl[3] ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (ctrl[3]) r = $signed(a) >>> b[4:0];
                    else         r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else begin
            legal = (ctrl[2:0] == 3'd0) || (ctrl[2:0] == 3'd3);
`ifdef EX_MUL_SIGNED_EN
            legal = legal || (ctrl[2:0] == 3'd1) || (ctrl[2:0] == 3'd2);
`endif
            if (ein != 3'd0) r = 32'd0;
            else if (!legal) e = 3'd4;
            else if (!bub) begin
                lat = 32;
                case (ctrl[2:0])
                    3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                    3'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
                    default: p = {32'd0, a} * {32'd0, b};
                endcase
                r = (ctrl[2:0] == 3'd0) ? p[31:0] : p[63:32];
            end
        end
    endtask

    task automatic run_op(input logic [4:0] ctrl, input logic [31:0] x, input logic [31:0] y,
                          input logic xr, input logic yr, input logic [2:0] dst, input logic bn,
                          input logic bi, input logic [2:0] err, input int hold);
        logic [31:0] ox, oy, eres, pc, imm;
        logic [2:0]  eerr, extra, mem;
        logic [1:0]  wb;
        int          elat, n;
        ox = opnd(x, xr);
        oy = opnd(y, yr);
        model(ctrl, ox, oy, bn | bi, err, eres, eerr, elat);
        pc = $urandom; imm = $urandom; extra = 3'($urandom); mem = 3'($urandom); wb = 2'($urandom);
        id_alu_ctrl = ctrl; id_data_x = x; id_data_y = y; id_is_x_reg = xr; id_is_y_reg = yr;
        id_dest = dst; nop = bn; id_nop_statue = bi; id_error_code = err;
        id_current_pc_addr = pc; id_data_imm = imm; id_reg_extra = extra; id_mem_ctrl = mem; id_wb_ctrl = wb;
        enable = (hold == 0);
        #1;
        check("rs1_index", 64'(rs1), 64'(x[2:0]));
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                // Upstream fields are scrambled mid-multiply; the stage must use its issue-time copies.
                id_data_x = $urandom; id_data_y = $urandom; id_dest = 3'($urandom); id_reg_extra = 3'($urandom);
                id_current_pc_addr = $urandom; id_data_imm = $urandom; id_mem_ctrl = 3'($urandom);
                id_wb_ctrl = 2'($urandom); nop = 1'($urandom);
            end
        end
        check("latency", 64'(n), 64'(elat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_done", 64'(done), 64'd1);
            check("hold_res", 64'(res), 64'(exp_res));
        end
        enable = 1'b1;
        @(posedge clk); #1;
        check("res", 64'(res), 64'(eres));
        check("error_code", 64'(error_code), 64'(eerr));
        check("nop_statue", 64'(nop_statue), 64'(bn | bi));
        check("passthru", 64'({dest, reg_extra, wb_ctrl, mem_ctrl}), 64'({dst, extra, wb, mem}));
        check("pc_imm", {current_pc_addr, data_imm}, {pc, imm});
        exp_res = eres; exp_dest = dst; exp_nop = bn | bi; exp_err = eerr;
        id_alu_ctrl = 5'd0; enable = 1'b0; nop = 1'b0; id_nop_statue = 1'b0; id_error_code = 3'd0;
    endtask

    initial begin
        logic [4:0]  ctrl;
        logic [31:0] x, y;
        logic        xr;
        for (int i = 0; i < 8; i++) rf[i] = $urandom;
        reset = 1'b1; enable = 1'b0; nop = 1'b0; id_alu_ctrl = 5'd0; id_data_x = 32'd0; id_data_y = 32'd0;
        id_is_x_reg = 1'b0; id_is_y_reg = 1'b0; id_current_pc_addr = 32'd0; id_dest = 3'd0; id_reg_extra = 3'd0;
        id_wb_ctrl = 2'd0; id_mem_ctrl = 3'd0; id_data_imm = 32'd0; id_nop_statue = 1'b0; id_error_code = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", 64'(res), 64'd0);
        check("rst_nop", 64'(nop_statue), 64'd1);
        check("rst_err", 64'(error_code), 64'd0);
        check("rst_done", 64'(done), 64'd1);
        check("rst_dest", 64'(dest), 64'd0);
        reset = 1'b0;
        exp_res = 32'd0; exp_dest = 3'd0; exp_nop = 1'b1; exp_err = 3'd0;

        run_op(5'b00000, 32'd5, 32'hFFFF_FFFB, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 0);
        check("tp_add", 64'(res), 64'd0);
        run_op(5'b10000, 32'h0001_0003, 32'd7, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0, 0);
        check("tp_mul", 64'(res), 64'h0007_0015);
        run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, 3);
        check("tp_mulhu", 64'(res), 64'hFFFF_FFFE);
        run_op(5'b00000, 32'd10, 32'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 0);
        run_op(5'b01000, 32'd1, 32'd3, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 0);
        check("tp_fwd", 64'(res), 64'd7);
        run_op(5'b00000, 32'd10, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0);
        run_op(5'b01000, 32'd0, 32'd3, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 0);
        check("tp_nofwd", 64'(res), 64'(rf[0] - 32'd3));

        id_alu_ctrl = 5'b10000; id_data_x = 32'd1234; id_data_y = 32'd77; enable = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1; id_alu_ctrl = 5'd0;
        #1;
        check("arst_res", 64'(res), 64'd0);
        check("arst_nop", 64'(nop_statue), 64'd1);
        check("arst_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b0;
        exp_res = 32'd0; exp_dest = 3'd0; exp_nop = 1'b1; exp_err = 3'd0;
        run_op(5'b00000, 32'd40, 32'd2, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0, 0);

        run_op(5'b10001, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 0);
`ifdef EX_MUL_SIGNED_EN
        check("tp_mulh", 64'(res), 64'hFFFF_FFFF);
`else
        check("tp_mulh_illegal", 64'(error_code), 64'd4);
`endif

        for (int t = 0; t < 150; t++) begin
            ctrl = {($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom)};
            x = $urandom; y = $urandom;
            xr = 1'($urandom);
            if (xr && $urandom_range(0, 1) == 1) x[2:0] = exp_dest;
            run_op(ctrl, x, y, xr, 1'($urandom), 3'($urandom),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
